// File: rtl/rf_buf_xfer_if.sv
// Bundle of the transfer engine's command, stream and buffer-RAM signals.
// The engine side uses the master modport; the controller/RAM side uses slave.
interface rf_buf_xfer_if #(
    parameter int AW = 8,
    parameter int DW = 12
);
    // Handshakes: a word moves on a rising clk edge when valid and ready are both high
    // in the cycle before it. The side raising valid holds its data stable until that
    // edge. valid never waits on ready. ready may depend on state but never on valid.
    logic          start;
    logic          dir;
    logic [AW-1:0] base;
    logic [AW-1:0] count;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_ce;
    logic          ram_we;
    logic [DW-1:0] cksum;

    modport master (
        input  start, dir, base, count, in_valid, in_data, out_ready, ram_dout,
        output busy, done, in_ready, out_valid, out_data, ram_a, ram_din, ram_ce, ram_we, cksum
    );

    modport slave (
        output start, dir, base, count, in_valid, in_data, out_ready, ram_dout,
        input  busy, done, in_ready, out_valid, out_data, ram_a, ram_din, ram_ce, ram_we, cksum
    );
endinterface

// File: rtl/rf_buf_xfer.sv
// Block-transfer engine for the RF 256x12 buffer RAM: fill (stream->RAM) and drain (RAM->stream).
// Optional running checksum enabled by defining RF_BUF_CKSUM_EN.
module rf_buf_xfer #(
    parameter int AW = 8,
    parameter int DW = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    rf_buf_xfer_if.master        bus,
    output logic [2:0]           dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [AW:0] REM_ONE = 1;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic          done_q, done_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.base;
                    // count of zero encodes a full 256-word block
                    rem_d   = (bus.count == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, bus.count};
                    state_d = bus.dir ? S_FILL : S_RD;
                end
            end
            S_FILL: begin
                if (bus.in_valid) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == REM_ONE) state_d = S_DONE;
                end
            end
            S_RD: begin
                out_data_d  = bus.ram_dout;
                out_valid_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    addr_d      = addr_q + 1'b1;
                    rem_d       = rem_q - 1'b1;
                    state_d     = (rem_q == REM_ONE) ? S_DONE : S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // RAM strobes are gated by reset so an aborted fill never writes in the reset cycle.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.ram_a    = addr_q;
        bus.ram_din  = '0;
        bus.ram_ce   = 1'b0;
        bus.ram_we   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FILL: begin
                    bus.in_ready = 1'b1;
                    bus.ram_din  = bus.in_data;
                    bus.ram_ce   = bus.in_valid;
                    bus.ram_we   = bus.in_valid;
                end
                S_RD:    bus.ram_ce = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign dbg_state_o   = state_q;

`ifdef RF_BUF_CKSUM_EN
    logic [DW-1:0] cksum_q, cksum_d;

    // 12-bit wraparound sum of every word that crosses either stream handshake
    always_comb begin
        cksum_d = cksum_q;
        if (state_q == S_IDLE && bus.start)
            cksum_d = '0;
        else if (state_q == S_FILL && bus.in_valid)
            cksum_d = cksum_q + bus.in_data;
        else if (state_q == S_WAIT && bus.out_ready)
            cksum_d = cksum_q + out_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) cksum_q <= '0;
        else       cksum_q <= cksum_d;
    end

    assign bus.cksum = cksum_q;
`else
    assign bus.cksum = '0;
`endif
endmodule

// File: tb/tb_rf_buf_xfer.sv
// Directed bench for rf_buf_xfer: behavioural buffer RAM, expected-word queue, single check task.
`timescale 1ns/1ps
module tb_rf_buf_xfer;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;

    rf_buf_xfer_if #(.AW(8), .DW(12)) bus ();

    rf_buf_xfer #(.AW(8), .DW(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

`ifdef RF_BUF_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    // Buffer RAM model with a preload port that only the bench uses while the DUT is idle
    logic [11:0] mem [256];
    int          wr_total = 0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [11:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.ram_ce && bus.ram_we) begin
            mem[bus.ram_a] <= bus.ram_din;
            wr_total       <= wr_total + 1;
        end
    end
    assign bus.ram_dout = mem[bus.ram_a];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o (octal) expected %0o (octal)", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [11:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        cyc();
        pl_en = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.dir = 1'b0; bus.base = '0; bus.count = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_state"},     dbg_state,     0);
        chk({pfx, "_busy"},      bus.busy,      0);
        chk({pfx, "_done"},      bus.done,      0);
        chk({pfx, "_in_ready"},  bus.in_ready,  0);
        chk({pfx, "_out_valid"}, bus.out_valid, 0);
        chk({pfx, "_out_data"},  bus.out_data,  0);
        chk({pfx, "_ram_ce"},    bus.ram_ce,    0);
        chk({pfx, "_ram_we"},    bus.ram_we,    0);
        chk({pfx, "_cksum"},     bus.cksum,     0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        int dn;
        int errs;
        logic tog;

        reset = 1'b1;
        idle_inputs();
        cyc(); cyc();
        chk_reset_outputs("reset");
        reset = 1'b0;
        cyc();

        // Fill across the top of the buffer: 374..377 then 000..001
        w0 = wr_total;
        bus.start = 1'b1; bus.dir = 1'b1; bus.base = 8'o374; bus.count = 8'd6;
        bus.in_valid = 1'b1; bus.in_data = 12'o1;
        cyc();
        bus.start = 1'b0;
        chk("fill_busy", bus.busy, 1);
        for (int k = 1; k <= 6; k++) begin
            bus.in_data = 12'(k);
            #1;
            chk("fill_we", bus.ram_we, 1);
            chk("fill_addr", bus.ram_a, 8'(8'o374 + k - 1));
            chk("fill_din", bus.ram_din, k);
            chk("fill_done_early", bus.done, 0);
            cyc();
        end
        chk("fill_done", bus.done, 1);
        chk("fill_done_busy", bus.busy, 1);
        chk("fill_cksum", bus.cksum, CK_EN ? 12'o25 : 12'o0);
        bus.in_valid = 1'b0;
        cyc();
        chk("fill_done_once", bus.done, 0);
        chk("fill_idle_busy", bus.busy, 0);
        chk("fill_ram374", mem[8'o374], 12'o1);
        chk("fill_ram377", mem[8'o377], 12'o4);
        chk("fill_ram000", mem[8'o000], 12'o5);
        chk("fill_ram001", mem[8'o001], 12'o6);
        chk("fill_writes", wr_total - w0, 6);

        // Drain with out_ready toggling 1,0,1,0...
        preload(8'o20, 12'o7777);
        preload(8'o21, 12'o1234);
        preload(8'o22, 12'o0000);
        preload(8'o23, 12'o4321);
        exp_q = {12'o7777, 12'o1234, 12'o0000, 12'o4321};
        bus.start = 1'b1; bus.dir = 1'b0; bus.base = 8'o20; bus.count = 8'd4; bus.out_ready = 1'b0;
        cyc();
        bus.start = 1'b0;
        tog = 1'b1;
        dn = 0;
        for (int c = 0; c < 40 && dn == 0; c++) begin
            bus.out_ready = tog;
            tog = ~tog;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("drain_extra_word", exp_q.size(), 1);
                else begin
                    chk("drain_data", bus.out_data, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.done) dn++;
            cyc();
        end
        chk("drain_done_seen", dn, 1);
        chk("drain_words_left", exp_q.size(), 0);
        chk("drain_done_once", bus.done, 0);
        chk("drain_cksum", bus.cksum, CK_EN ? 12'o5554 : 12'o0);
        bus.out_ready = 1'b0;
        cyc();

        // count=0 means 256 words
        w0 = wr_total;
        bus.start = 1'b1; bus.dir = 1'b1; bus.base = 8'd0; bus.count = 8'd0;
        bus.in_valid = 1'b1; bus.in_data = '0;
        cyc();
        bus.start = 1'b0;
        dn = 0;
        for (int k = 0; k < 256; k++) begin
            bus.in_data = 12'(k);
            if (bus.done) dn++;
            cyc();
        end
        chk("f256_done_early", dn, 0);
        chk("f256_done", bus.done, 1);
        chk("f256_writes", wr_total - w0, 256);
        chk("f256_cksum", bus.cksum, CK_EN ? 12'd3968 : 12'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("f256_no_we_after", bus.ram_we, 0);
        end
        bus.in_valid = 1'b0;
        errs = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== 12'(k)) errs++;
        chk("f256_ram_bad_words", errs, 0);

        // Fill with a 5-cycle stall after three words
        w0 = wr_total;
        bus.start = 1'b1; bus.dir = 1'b1; bus.base = 8'd100; bus.count = 8'd8;
        bus.in_valid = 1'b1; bus.in_data = 12'o100;
        cyc();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = 12'(12'o100 + k);
            cyc();
        end
        bus.in_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_we", bus.ram_we, 0);
            chk("stall_addr", bus.ram_a, 103);
            chk("stall_in_ready", bus.in_ready, 1);
            cyc();
        end
        bus.in_valid = 1'b1;
        for (int k = 3; k < 8; k++) begin
            bus.in_data = 12'(12'o100 + k);
            chk("stall_done_early", bus.done, 0);
            cyc();
        end
        chk("stall_done", bus.done, 1);
        bus.in_valid = 1'b0;
        cyc();
        chk("stall_writes", wr_total - w0, 8);
        errs = 0;
        for (int k = 0; k < 8; k++) if (mem[100 + k] !== 12'(12'o100 + k)) errs++;
        chk("stall_ram_bad_words", errs, 0);

        // start pulsed during an active drain is ignored
        preload(8'd40, 12'o1111);
        preload(8'd41, 12'o2222);
        preload(8'd42, 12'o3333);
        exp_q = {12'o1111, 12'o2222, 12'o3333};
        w0 = wr_total;
        bus.start = 1'b1; bus.dir = 1'b0; bus.base = 8'd40; bus.count = 8'd3;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 12'o7070;
        cyc();
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) begin
                bus.start = 1'b1; bus.dir = 1'b1; bus.base = 8'd0; bus.count = 8'd5;
            end else bus.start = 1'b0;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("sib_extra_word", exp_q.size(), 1);
                else begin
                    chk("sib_data", bus.out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            chk("sib_done_timing", bus.done, (c == 7));
            cyc();
        end
        chk("sib_words_left", exp_q.size(), 0);
        chk("sib_no_writes", wr_total - w0, 0);
        chk("sib_idle", bus.busy, 0);
        idle_inputs();

        // Reset while waiting on out_ready
        preload(8'd60, 12'o5252);
        preload(8'd61, 12'o1616);
        w0 = wr_total;
        bus.start = 1'b1; bus.dir = 1'b0; bus.base = 8'd60; bus.count = 8'd2; bus.out_ready = 1'b0;
        cyc();
        bus.start = 1'b0;
        cyc();
        chk("rst_wait_valid", bus.out_valid, 1);
        chk("rst_wait_data", bus.out_data, 12'o5252);
        reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 12'o7777;
        cyc();
        chk_reset_outputs("rst_wait");
        reset = 1'b0; bus.in_valid = 1'b0;
        cyc();
        chk("rst_ram60", mem[60], 12'o5252);
        chk("rst_ram61", mem[61], 12'o1616);
        chk("rst_idle_busy", bus.busy, 0);

        // Reset during a fill handshake cycle must not write
        bus.start = 1'b1; bus.dir = 1'b1; bus.base = 8'd200; bus.count = 8'd4;
        bus.in_valid = 1'b1; bus.in_data = 12'o7;
        cyc();
        bus.start = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_fill_we", bus.ram_we, 0);
        chk("rst_fill_in_ready", bus.in_ready, 0);
        cyc();
        reset = 1'b0; bus.in_valid = 1'b0;
        cyc();
        chk("rst_fill_writes", wr_total - w0, 0);
        chk("rst_fill_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
